// File: rtl/aes_enc_ctrl.sv
// ============================================================================
// Module   : aes_enc_ctrl
// Brief    : Iterative AES-128 encryption sequencer, one round per clock over
//            a single 128-bit state register and shared round datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_enc_ctrl #(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [127:0]        plaintext_i,
  input  logic                abort_i,
  output logic [RK_IDX_W-1:0] rk_idx_o,
  input  logic [127:0]        rk_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [127:0]        ciphertext_o,
  output logic                busy_o
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [RK_IDX_W-1:0] c_LAST = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] c_ONE  = RK_IDX_W'(1);

  logic [1:0]          state_q, state_d;
  logic [RK_IDX_W-1:0] round_cnt_q, round_cnt_d;
  logic [127:0]        state_reg_q, state_reg_d;
  logic                w_accept;
  logic                w_last;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from the field inverse a^254 (0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte n of a block sits at bits [127-8n -: 8]; byte n = row (n%4), column (n/4).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] sr;
    logic [127:0] mc;
    logic [7:0]   a0, a1, a2, a3;
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(15-(r+4*c)) +: 8] = sbox(s[8*(15-(r+4*((c+r)%4))) +: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[8*(15-4*c) +: 8];
      a1 = sr[8*(14-4*c) +: 8];
      a2 = sr[8*(13-4*c) +: 8];
      a3 = sr[8*(12-4*c) +: 8];
      mc[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return (last ? sr : mc) ^ k;
  endfunction

  assign w_accept = in_valid_i && (state_q == c_IDLE);
  assign w_last   = (round_cnt_q == c_LAST);

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    state_reg_d = state_reg_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          state_reg_d = plaintext_i ^ rk_i;
          round_cnt_d = c_ONE;
          state_d     = c_RUN;
        end
      end
      c_RUN: begin
        state_reg_d = aes_round(state_reg_q, rk_i, w_last);
        if (w_last) state_d = c_DONE;
        else        round_cnt_d = round_cnt_q + c_ONE;
      end
      c_DONE: begin
        if (out_ready_i) begin
          state_d     = c_IDLE;
          round_cnt_d = '0;
        end
      end
      default: begin
        state_d     = c_IDLE;
        round_cnt_d = '0;
      end
    endcase
    // Abort wins over any handshake seen in the same cycle.
    if (abort_i) begin
      state_d     = c_IDLE;
      round_cnt_d = '0;
      state_reg_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_IDLE;
      round_cnt_q <= '0;
      state_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      state_reg_q <= state_reg_d;
    end
  end

  // in_ready is masked by rst_n so upstream never sees a handshake during reset.
  assign in_ready_o   = rst_n && (state_q == c_IDLE);
  assign rk_idx_o     = (state_q == c_RUN) ? round_cnt_q : '0;
  assign out_valid_o  = (state_q == c_DONE);
  assign ciphertext_o = (state_q == c_DONE) ? state_reg_q : '0;
  assign busy_o       = (state_q == c_RUN) || (state_q == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_aes_enc_ctrl.sv
// ============================================================================
// Module   : tb_aes_enc_ctrl
// Brief    : Self-checking bench for aes_enc_ctrl against a byte-level AES model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_enc_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic         abort = 1'b0;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ct;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rks [0:NR];

  aes_enc_ctrl #(.NR(NR), .RK_IDX_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .plaintext_i (plaintext),
    .abort_i     (abort),
    .rk_idx_o    (rk_idx),
    .rk_i        (rk),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ciphertext_o(ct),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Key store: precomputed schedule, combinational lookup.
  assign rk = (rk_idx <= 4'(NR)) ? rks[rk_idx] : '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Walk the field by powers of 3 and their inverses to fill the S-box table.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    sbox_t[0] = 8'h63;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^
                  {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ rks[0][127-8*n -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          t[row+4*col] = s[row+4*((col+row)%4)];
      for (int n = 0; n < 16; n++) s[n] = t[n];
      if (r < NR) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*col+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rks[r][127-8*n -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block from IDLE; rks must already hold this block's schedule.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp_ct,
                           input int hold, input int abort_at);
    check("idle_in_ready", in_ready, 1);
    check("idle_rk_idx", rk_idx, 0);
    plaintext = pt;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      check("run_rk_idx", rk_idx, k);
      check("run_out_valid", out_valid, 0);
      check("run_in_ready", in_ready, 0);
      check("run_busy", busy, 1);
      if ($urandom_range(0, 3) == 0) begin
        in_valid  = 1'b1;
        plaintext = rand128();
      end
      if (k == abort_at) abort = 1'b1;
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      if (k == abort_at) begin
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_rk_idx", rk_idx, 0);
        for (int j = 0; j < NR + 2; j++) begin
          check("abort_no_valid", out_valid, 0);
          step();
        end
        return;
      end
    end
    check("done_out_valid", out_valid, 1);
    check("done_ct", ct, exp_ct);
    check("done_busy", busy, 1);
    out_ready = 1'b0;
    for (int j = 0; j < hold; j++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      plaintext = rand128();
      step();
      check("hold_out_valid", out_valid, 1);
      check("hold_ct", ct, exp_ct);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("taken_out_valid", out_valid, 0);
    check("taken_ct", ct, 0);
    check("taken_in_ready", in_ready, 1);
  endtask

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] pts [2];
    logic [127:0] keys [2];
    logic [127:0] exps [2];
    logic [127:0] key, pt;
    int acc [2];
    int blk, got, cyc, exp_idx, ab;

    build_sbox();
    expand(KEY_B);

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rk_idx", rk_idx, 0);
    check("rst_ct", ct, 0);
    #5 rst_n = 1'b1;
    step();

    // FIPS-197 vectors, then long backpressure.
    expand(KEY_B); run_block(PT_B, CT_B, 0, 0);
    expand(KEY_C); run_block(PT_C, CT_C, 2, 0);
    expand(KEY_B); run_block(PT_B, CT_B, 20, 0);

    // Back-to-back with in_valid and out_ready held high.
    pts[0] = PT_B; keys[0] = KEY_B; exps[0] = CT_B;
    pts[1] = PT_C; keys[1] = KEY_C; exps[1] = CT_C;
    acc[0] = -100; acc[1] = -1000;
    blk = 0; got = 0; cyc = 0; exp_idx = 0;
    expand(keys[0]);
    plaintext = pts[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < 2 && cyc < 60) begin
      if (busy && !out_valid) begin
        check("b2b_rk_idx", rk_idx, exp_idx);
        exp_idx++;
      end
      if (in_valid && in_ready && blk < 2) begin
        check("b2b_accept_rk_idx", rk_idx, 0);
        acc[blk] = cyc;
        blk++;
        exp_idx = 1;
      end
      if (out_valid) begin
        check("b2b_ct", ct, exps[got]);
        got++;
        if (got == 1) begin
          expand(keys[1]);
          plaintext = pts[1];
        end else begin
          in_valid = 1'b0;
        end
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_blocks", got, 2);
    check("b2b_spacing", acc[1] - acc[0], NR + 2);
    step();

    // Abort at round 5, then a clean block.
    expand(KEY_B); run_block(PT_B, CT_B, 0, 5);
    run_block(PT_B, CT_B, 1, 0);

    // Asynchronous reset during round 7.
    expand(KEY_C);
    plaintext = PT_C;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 7; k++) step();
    check("pre_rst_rk_idx", rk_idx, 7);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rk_idx", rk_idx, 0);
    check("mid_rst_ct", ct, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    for (int j = 0; j < NR + 2; j++) begin
      check("post_rst_no_valid", out_valid, 0);
      step();
    end

    // Randomized blocks with random backpressure and occasional aborts.
    for (int b = 0; b < 24; b++) begin
      key = rand128();
      pt  = rand128();
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NR)) : 0;
      expand(key);
      run_block(pt, ref_aes(pt), int'($urandom_range(0, 4)), ab);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
